// File: rtl/permutation_ctrl_pkg.sv
// ============================================================================
// Module : permutation_ctrl_pkg
// Brief  : Shared types, widths and round-count helpers for the Ascon
//          permutation sequencing controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package permutation_ctrl_pkg;

    localparam int unsigned ROUND_W = 4;

    localparam logic [ROUND_W-1:0] ROUNDS_MAX  = 4'd12;
    localparam logic [ROUND_W-1:0] ROUNDS_MIN  = 4'd1;
    localparam logic [ROUND_W-1:0] ROUNDS_PA   = 4'd12;
    localparam logic [ROUND_W-1:0] ROUNDS_PB8  = 4'd8;
    localparam logic [ROUND_W-1:0] ROUNDS_PB6  = 4'd6;
    localparam logic [ROUND_W-1:0] ROUND_LAST  = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_perm_fsm;

    // Saturate a requested round count into the supported 1..12 range.
    function automatic logic [ROUND_W-1:0] clamp_rounds(input logic [ROUND_W-1:0] rounds);
        logic [ROUND_W-1:0] v_r;
        v_r = rounds;
        if (rounds < ROUNDS_MIN) begin
            v_r = ROUNDS_MIN;
        end else if (rounds > ROUNDS_MAX) begin
            v_r = ROUNDS_MAX;
        end
        return v_r;
    endfunction

    // The last N rounds of p^12 are executed, so the first index is 12-N.
    function automatic logic [ROUND_W-1:0] start_index(input logic [ROUND_W-1:0] rounds);
        return ROUNDS_MAX - clamp_rounds(rounds);
    endfunction

    function automatic logic is_legal_rounds(input logic [ROUND_W-1:0] rounds);
        return (rounds == ROUNDS_PA) || (rounds == ROUNDS_PB8) || (rounds == ROUNDS_PB6);
    endfunction

endpackage

`default_nettype wire

// File: rtl/permutation_ctrl_round_counter.sv
// ============================================================================
// Module : round_counter
// Brief  : 4-bit round index counter with synchronous load/increment,
//          asynchronous reset and a last-round flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module round_counter
    import permutation_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [ROUND_W-1:0] i_load_val,
    input  logic               i_inc,
    output logic [ROUND_W-1:0] o_count,
    output logic               o_last
);

    logic [ROUND_W-1:0] r_count;

    // Load has priority so a back-to-back start overrides any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == ROUND_LAST);

endmodule

`default_nettype wire

// File: rtl/permutation_ctrl.sv
// ============================================================================
// Module : permutation_ctrl
// Brief  : Sequences the Ascon round datapath for p^a / p^b permutations.
//          Optional macro ASCON_ROUNDS_CHECK_EN rejects round counts other
//          than 6, 8 or 12 with a one-cycle err_o pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module permutation_ctrl
    import permutation_ctrl_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [ROUND_W-1:0] rounds_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               first_o,
    output logic               state_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    type_perm_fsm       r_state;
    type_perm_fsm       w_next_state;
    logic               r_first;
    logic               w_can_accept;
    logic               w_accept;
    logic               w_inc;
    logic               w_last;
    logic [ROUND_W-1:0] w_count;
    logic [ROUND_W-1:0] w_load_val;

    assign w_can_accept = (r_state == IDLE) || (r_state == DONE);
    assign w_load_val   = start_index(rounds_i);
    assign w_inc        = (r_state == RUN) && !w_last;

`ifdef ASCON_ROUNDS_CHECK_EN
    logic r_err;
    logic w_reject;

    assign w_accept = start_i && w_can_accept && is_legal_rounds(rounds_i);
    assign w_reject = start_i && w_can_accept && !is_legal_rounds(rounds_i);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    assign err_o = r_err;
`else
    assign w_accept = start_i && w_can_accept;
    assign err_o    = 1'b0;
`endif

    round_counter u_round_counter (
        .clk        (clock_i),
        .rst        (reset_i),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_inc      (w_inc),
        .o_count    (w_count),
        .o_last     (w_last)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_first <= w_accept;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE,
            DONE:    w_next_state = w_accept ? RUN : IDLE;
            RUN:     w_next_state = w_last ? DONE : RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // Round index is gated so the datapath sees 0 outside a permutation.
    always_comb begin
        state_en_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        first_o    = 1'b0;
        round_o    = '0;
        case (r_state)
            RUN: begin
                state_en_o = 1'b1;
                busy_o     = 1'b1;
                first_o    = r_first;
                round_o    = w_count;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/permutation_ctrl.md
# permutation_ctrl

Sequencing controller for the Ascon permutation datapath: constant addition, substitution layer and linear diffusion layer. On a start request it runs the datapath for 12, 8 or 6 rounds (p^a / p^b) and drives the datapath control signals each cycle: round index, input-select and state-register enable. It signals completion with a one-cycle pulse. It sits between the Ascon mode FSM (initialisation, associated data, plaintext, finalisation) and the combinational round datapath, which executes one round per clock.

## Interface
- No parameters; widths come from the shared package.
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request one permutation; sampled only when the block can accept
- rounds_i  in  4  number of rounds requested (nominal 12, 8 or 6); sampled with start_i
- round_o  out  4  Ascon round index r (0..11) fed to constant addition
- first_o  out  1  datapath input mux select: 1 = external state, 0 = feedback
- state_en_o  out  1  state register enable (one round per enabled cycle)
- busy_o  out  1  permutation in progress
- done_o  out  1  one-cycle pulse: state register holds permuted result
- err_o  out  1  one-cycle illegal-rounds pulse (only with ASCON_ROUNDS_CHECK_EN)

Clock and reset are decided: one clock, `clock_i`; reset `reset_i` is asynchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On start_i=1, load the round counter with 12−rounds_i, then go to RUN.
  - Otherwise remain in IDLE.
- **RUN**
  - Every cycle: state_en_o=1, busy_o=1, round_o=counter.
  - first_o=1 only in the first RUN cycle.
  - If counter==11, go to DONE. Otherwise increment the counter.
- **DONE**
  - done_o=1, busy_o=0.
  - A start_i here is accepted exactly as in IDLE (back-to-back permutations, no bubble). Otherwise go to IDLE.
- start_i in RUN is ignored; no queuing.
- Without the macro, rounds_i is clamped to 1..12: 0 is treated as 1, and 13–15 are treated as 12.
- Counter arithmetic is 4-bit unsigned. It never exceeds 11, so there is no wrap-around.
- Outputs are Moore decodes of state and counter. They are glitch-free and registered-state driven.

## Timing
- Reset values:
  - FSM in IDLE, counter 0.
  - round_o=0, first_o=0, state_en_o=0, busy_o=0, done_o=0, err_o=0.
- Start accepted at edge T:
  - RUN cycles occupy T+1 .. T+N, where N is the effective round count.
  - done_o is high during cycle T+N+1.
  - Latency from start to done_o is N+1 cycles.
- Round sequence for N=6: round_o = 6,7,8,9,10,11.
- Back-to-back: with start_i high in the DONE cycle, the next RUN begins the following cycle. first_o=1 on that cycle.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronous) and the permutation is abandoned. After release the block is in IDLE and needs a fresh start_i.

## Configuration
- Macro: `ASCON_ROUNDS_CHECK_EN`.
- Defined:
  - Only rounds_i ∈ {6, 8, 12} is accepted.
  - Any other value with start_i in IDLE or DONE: err_o=1 for exactly the next cycle, FSM goes or stays in IDLE, state_en_o stays 0.
- Undefined:
  - err_o is tied to 0.
  - The clamping rule applies and every start is accepted.

## Structure
- Shared package additions:
  - state enum type_perm_fsm {IDLE, RUN, DONE}
  - constant ROUNDS_MAX=12
  - constant ROUND_W=4
  - constants for the legal round counts (6, 8, 12)
- One sub-module: `round_counter`, a 4-bit counter with synchronous load and increment, asynchronous reset, and a last-round flag output (count==11).
- The FSM lives in permutation_ctrl.

## Test plan
- Reset, then start_i with rounds_i=12 → round_o 0..11 over 12 cycles, first_o high in cycle 1 only, state_en_o high for 12 cycles, done_o pulse in cycle 13.
- rounds_i=6 → round_o 6..11, done_o 7 cycles after the start edge. Then rounds_i=8 issued in the DONE cycle → round_o 4..11 with no idle gap.
- start_i held high throughout RUN → ignored, sequence unchanged, exactly one done_o pulse per accepted start.
- reset_i asserted at round_o=5 → all outputs 0 immediately. After release, no activity until a new start_i.
- Without the macro, rounds_i=0 → one round at round_o=11; rounds_i=15 → 12 rounds.
- With the macro, rounds_i=7 → err_o one cycle, state_en_o never asserted, busy_o stays 0.
